// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage buffer.
package pipe_pkg;

    // Occupancy of the two-entry stage: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// Parametrised payload register: async active-low reset, synchronous clear
// to RESET_VALUE (clear wins over load), and a load enable.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int                 WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-value select: clear, then load, else hold.
    always_comb begin
        // NOTE: default assigned first so every path drives data_d; no latch.
        data_d = data_q;
        if (clear) begin
            data_d = RESET_VALUE;
        end else if (load) begin
            data_d = d;
        end
    end

    // Storage flop; reset so no stale payload survives a reset.
    always_ff @(posedge clock or negedge resetN) begin
        // NOTE: non-blocking assignment for state so all flops update together.
        if (!resetN) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : pipe_data_reg

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid-buffered pipeline stage with registered inReady and
// one-cycle latency. Optional stall counter enabled by the macro
// PIPE_STAGE_BUFFER_STATS_EN; without it stallCount is tied to zero.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 flush,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [WIDTH-1:0]     inData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [WIDTH-1:0]     outData,
    output logic [CNT_WIDTH-1:0] stallCount
);

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             xfer_in;
    logic             xfer_out;
    logic             out_valid;

    assign out_valid = (state_q != EMPTY);
    assign xfer_in   = inValid && in_ready_q;
    assign xfer_out  = out_valid && outReady;

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_din  = inData;
        if (!flush) begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end else if (xfer_in) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (xfer_out) begin
                        main_din  = skid_q;
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    // State and registered ready; ready stays low throughout reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .clock  (clock),
        .resetN (resetN),
        .clear  (flush),
        .load   (main_load),
        .d      (main_din),
        .q      (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clock  (clock),
        .resetN (resetN),
        .clear  (flush),
        .load   (skid_load),
        .d      (inData),
        .q      (skid_q)
    );

    assign inReady  = in_ready_q;
    assign outValid = out_valid;
    assign outData  = main_q;

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    // Saturating count of cycles where a valid payload is held back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !outReady && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter flop; only reset clears it, flush leaves it alone.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
`else
    assign stallCount = '0;
`endif

endmodule : pipe_stage_buffer

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based model of the stage.
module tb_pipe_stage_buffer;

    localparam int               WIDTH     = 32;
    localparam int               CNT_WIDTH = 4;
    localparam logic [WIDTH-1:0] RV        = '0;
    localparam int               CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clock;
    logic                 resetN;
    logic                 flush;
    logic                 inValid;
    logic                 inReady;
    logic [WIDTH-1:0]     inData;
    logic                 outValid;
    logic                 outReady;
    logic [WIDTH-1:0]     outData;
    logic [CNT_WIDTH-1:0] stallCount;

    pipe_stage_buffer #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .stallCount (stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: an ordered queue of at most two payloads.
    logic [WIDTH-1:0] mq[$];
    logic             m_ready;
    logic [WIDTH-1:0] m_hold;
    int               m_stall;
    int               tests;
    int               fails;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, WIDTH'(outValid), WIDTH'(mq.size() > 0));
        check({tag, ".ready"}, WIDTH'(inReady), WIDTH'(m_ready));
        check({tag, ".data"}, outData, m_hold);
        check({tag, ".stall"}, WIDTH'(stallCount), WIDTH'(m_stall));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b0;
        m_hold  = RV;
        m_stall = 0;
    endtask

    // One clock edge of the model, using the inputs the DUT sees.
    task automatic model_edge();
        bit xin;
        bit xout;
        xin  = inValid && m_ready;
        xout = (mq.size() > 0) && outReady;
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        if ((mq.size() > 0) && !outReady && (m_stall < CNT_MAX)) m_stall++;
`endif
        if (flush) begin
            mq.delete();
            m_hold = RV;
        end else begin
            if (xout) void'(mq.pop_front());
            if (xin) mq.push_back(inData);
            if (mq.size() > 0) m_hold = mq[0];
        end
        m_ready = (mq.size() < 2);
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle, check immediate outputs, release on a falling edge.
    task automatic do_reset();
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        check("rst.ready0", WIDTH'(inReady), '0);
        @(negedge clock);
        resetN = 1'b1;
        cycle("rst_rel");
        check("rst_rel.ready1", WIDTH'(inReady), WIDTH'(1));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        resetN   = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        model_reset();

        // Reset sequence.
        do_reset();

        // Streaming 1,2,3 with downstream always ready.
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            inData = WIDTH'(i);
            cycle("stream");
            check("stream.data", outData, WIDTH'(i));
            check("stream.ready", WIDTH'(inReady), WIDTH'(1));
        end
        inValid = 1'b0;
        cycle("stream_drain");

        // Backpressure: fill to FULL, then drain in order.
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 32'hA;
        cycle("bp_a");
        inData = 32'hB;
        cycle("bp_b");
        check("bp.full_ready", WIDTH'(inReady), '0);
        check("bp.head_a", outData, 32'hA);
        inValid  = 1'b0;
        outReady = 1'b1;
        cycle("bp_pop_a");
        check("bp.head_b", outData, 32'hB);
        cycle("bp_pop_b");
        check("bp.empty", WIDTH'(outValid), '0);

        // Flush while FULL with a payload offered.
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 32'h1;
        cycle("fl_fill1");
        inData = 32'h2;
        cycle("fl_fill2");
        inData = 32'hC;
        flush  = 1'b1;
        cycle("flush");
        flush   = 1'b0;
        inValid = 1'b0;
        check("flush.valid", WIDTH'(outValid), '0);
        check("flush.data", outData, RV);
        check("flush.ready", WIDTH'(inReady), WIDTH'(1));
        outReady = 1'b1;
        repeat (3) cycle("flush_after");

        // Stall counter saturation with a held payload.
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 32'h5;
        cycle("stall_load");
        inValid = 1'b0;
        repeat (20) cycle("stall");
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        check("stall.sat", WIDTH'(stallCount), WIDTH'(CNT_MAX));
`else
        check("stall.off", WIDTH'(stallCount), '0);
`endif

        // Reset while FULL discards everything.
        inValid = 1'b1;
        inData  = 32'hD1;
        cycle("rf_fill");
        inData = 32'hD2;
        cycle("rf_full");
        inValid = 1'b0;
        do_reset();
        outReady = 1'b1;
        repeat (3) begin
            cycle("rf_after");
            check("rf_after.valid", WIDTH'(outValid), '0);
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if (n % 100 > 60) outReady = 1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
            inData   = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle("rand");
            end
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_stage_buffer
